imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, synchronous-read unified instruction/data memory between the IF stage (fetch port) and the MEM stage (data port) of the pipelined core.
- Each cycle, grants at most one requester and drives the memory.
- Routes the one-cycle-late read data back to the owner.
- Enforces data-over-fetch priority with an anti-starvation guard for fetch.

Parameters:
- ADDR_W, 6, word-address width (64-word memory)
- DATA_W, 32, word width
- STARVE_LIMIT, 4, consecutive contended data grants before fetch is forced through (range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetched instruction, held between responses
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  4  byte enables for store
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data / store ack (cycle after d_gnt)
- d_rdata  out  DATA_W  load data, held between responses
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Memory contract:
  - Accepts one access per cycle (fully pipelined).
  - Read data appears at mem_rdata exactly 1 cycle after the access.
  - Writes commit at the clock edge.
- Grant logic is combinational from req, starvation state and rst:
  - Only d_req: d_gnt=1.
  - Only if_req: if_gnt=1.
  - Both: d_gnt=1 unless starve_cnt==STARVE_LIMIT, in which case if_gnt=1.
  - Neither: no grant, mem_en=0.
  - if_gnt and d_gnt are never both 1.
- Memory drive:
  - mem_en = if_gnt|d_gnt.
  - mem_we = d_gnt & d_we.
  - mem_addr, mem_wdata and mem_be are muxed from the granted port.
  - mem_we=0 and mem_be=0 on fetch.
  - When idle, mem_addr etc. are don't-care, but mem_we=0.
- Handshake:
  - A requester holds req and all payload stable until its gnt is seen high.
  - The requester may change its payload in the cycle after the grant.
  - Back-to-back grants to the same port are allowed.
- Response FSM: registered owner of the in-flight access, with states NONE, FETCH, DATA.
  - Next state = FETCH if if_gnt, DATA if d_gnt, else NONE.
  - In FETCH: if_rvalid=1, if_rdata=mem_rdata, and if_rdata_q captures mem_rdata.
  - In DATA: d_rvalid=1; for a load, d_rdata=mem_rdata and d_rdata_q captures it. A store only pulses d_rvalid, and d_rdata keeps d_rdata_q.
  - Outside a response, if_rdata=if_rdata_q and d_rdata=d_rdata_q. Fetch data therefore stays stable while IF is stalled.
  - The FSM registers whether the in-flight data access is a store.
- Starvation counter (starve_cnt, 4 bits):
  - Increments when d_gnt & if_req.
  - Clears when if_gnt, or when if_req=0.
  - Saturates at STARVE_LIMIT.
  - With continuous contention, this yields STARVE_LIMIT data grants followed by 1 fetch grant, repeating.
- d_be=0000 store: a legal no-op write; it is still granted and acked.
- Reset (async):
  - Owner=NONE, starve_cnt=0, if_rdata_q=0, d_rdata_q=0.
  - All gnt, rvalid and mem_en/mem_we outputs are 0 while rst=1.
  - An access granted in the cycle before rst asserts produces no rvalid after reset releases.
- No combinational path from mem_rdata to any gnt or mem_* output.

Test Plan:
- Fetch only: memory preloaded with word0=0x00002303 and word1=0x00402383; if_req=1, if_addr=0 then 1 -> if_gnt=1 both cycles; if_rvalid=1 the next cycles with if_rdata=0x00002303 then 0x00402383; d_gnt=0 throughout.
- Contention: fetch word0 returned, then if_req=1 & d_req=1 (load addr 2) -> d_gnt=1, if_gnt=0; d_rvalid next cycle with mem word2; if_rdata stays 0x00002303; starve_cnt=1.
- Starvation, STARVE_LIMIT=4: if_req and d_req held high for 10 cycles -> grant pattern D D D D F D D D D F; exactly 2 if_rvalid pulses.
- Byte-enable store: store addr 10, 0xDEADBEEF, be=1111; then store 0x12345678 be=0011; then load addr 10 -> d_rvalid each cycle after grant; load returns 0xDEAD5678.
- Reset mid-operation: fetch granted at cycle N, rst pulsed high in cycle N (async, before edge N+1) -> if_rvalid=0, if_rdata=0, all grants 0; after release, first fetch of addr 1 returns 0x00402383 one cycle after grant.
- Idle: if_req=d_req=0 for 5 cycles -> mem_en=0, mem_we=0, no rvalid; if_rdata/d_rdata unchanged.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Arbiter sharing one synchronous-read unified memory between the fetch port and the data port.
// Data wins contention; fetch is forced through after STARVE_LIMIT consecutive contended data grants.
module imem_dmem_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_NONE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);

  logic [1:0]        r_owner;
  logic              r_is_store;
  logic [3:0]        r_starve_cnt;
  logic [DATA_W-1:0] r_if_rdata_q;
  logic [DATA_W-1:0] r_d_rdata_q;
  logic              w_if_gnt;
  logic              w_d_gnt;

  // Grant selection: data first unless fetch has been starved to the limit.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (rst) begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end else if (d_req && !(if_req && (r_starve_cnt == LIMIT))) begin
      w_d_gnt = 1'b1;
    end else if (if_req) begin
      w_if_gnt = 1'b1;
    end else begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end
  end

  // Memory port mux driven from the granted requester.
  always_comb begin
    if_gnt    = w_if_gnt;
    d_gnt     = w_d_gnt;
    mem_en    = w_if_gnt | w_d_gnt;
    mem_we    = w_d_gnt & d_we;
    if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_be    = d_be;
    end else begin
      mem_addr  = if_addr;
      mem_wdata = {DATA_W{1'b0}};
      mem_be    = 4'b0000;
    end
  end

  // Owner of the in-flight access, starvation counter and held read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= ST_NONE;
      r_is_store   <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_if_rdata_q <= {DATA_W{1'b0}};
      r_d_rdata_q  <= {DATA_W{1'b0}};
    end else begin
      r_owner    <= w_if_gnt ? ST_FETCH : (w_d_gnt ? ST_DATA : ST_NONE);
      r_is_store <= w_d_gnt & d_we;
      if (w_if_gnt || !if_req) begin
        r_starve_cnt <= 4'd0;
      end else if (w_d_gnt && (r_starve_cnt < LIMIT)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
      case (r_owner)
        ST_FETCH: r_if_rdata_q <= mem_rdata;
        ST_DATA:  if (!r_is_store) r_d_rdata_q <= mem_rdata;
        default:  r_if_rdata_q <= r_if_rdata_q;
      endcase
    end
  end

  // Response routing: live memory data during a response, held copy otherwise.
  always_comb begin
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = r_if_rdata_q;
    d_rdata   = r_d_rdata_q;
    case (r_owner)
      ST_FETCH: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      ST_DATA: begin
        d_rvalid = 1'b1;
        d_rdata  = r_is_store ? r_d_rdata_q : mem_rdata;
      end
      default: begin
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench: behavioural memory, transaction-level reference model and directed vectors.
module tb_imem_dmem_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        preload = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [5:0]  if_addr = 6'd0, d_addr = 6'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [3:0]  d_be = 4'd0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  imem_dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 0) return 32'h00002303;
    if (i == 1) return 32'h00402383;
    if (i == 2) return 32'hCAFE0002;
    return 32'hA5A50000 | 32'(i);
  endfunction

  // Memory attached to the DUT's memory port.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  // Reference model: who is served, what comes back, what each port holds.
  logic [31:0] gmem [64];
  int          m_starve = 0;
  int          m_pend = 0;       // 0 none, 1 fetch, 2 load, 3 store
  logic [31:0] m_pdata = 32'd0;
  logic [31:0] m_if_hold = 32'd0;
  logic [31:0] m_d_hold = 32'd0;
  logic        m_ig, m_dg;
  assign m_ig = !rst && if_req && (!d_req || (m_starve == LIM));
  assign m_dg = !rst && d_req && !m_ig;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) gmem[i] <= init_word(i);
    end else if (m_dg && d_we) begin
      for (int b = 0; b < 4; b++)
        if (d_be[b]) gmem[d_addr][8*b +: 8] <= d_wdata[8*b +: 8];
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= 0; m_starve <= 0; m_if_hold <= 32'd0; m_d_hold <= 32'd0;
    end else begin
      if (m_pend == 1) m_if_hold <= m_pdata;
      if (m_pend == 2) m_d_hold <= m_pdata;
      m_pend  <= m_ig ? 1 : (m_dg ? (d_we ? 3 : 2) : 0);
      m_pdata <= m_ig ? gmem[if_addr] : gmem[d_addr];
      if (m_ig || !if_req) m_starve <= 0;
      else if (m_dg && m_starve < LIM) m_starve <= m_starve + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("if_gnt", 32'(if_gnt), 32'(m_ig));
      chk("d_gnt", 32'(d_gnt), 32'(m_dg));
      chk("mem_en", 32'(mem_en), 32'(m_ig | m_dg));
      chk("mem_we", 32'(mem_we), 32'(m_dg & d_we));
      if (m_dg) begin
        chk("mem_addr_d", 32'(mem_addr), 32'(d_addr));
        if (d_we) begin
          chk("mem_wdata", mem_wdata, d_wdata);
          chk("mem_be_d", 32'(mem_be), 32'(d_be));
        end
      end else if (m_ig) begin
        chk("mem_addr_if", 32'(mem_addr), 32'(if_addr));
        chk("mem_be_if", 32'(mem_be), 32'd0);
      end
      chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
      chk("d_rvalid", 32'(d_rvalid), 32'(m_pend >= 2));
      chk("if_rdata", if_rdata, (m_pend == 1) ? m_pdata : m_if_hold);
      chk("d_rdata", d_rdata, (m_pend == 2) ? m_pdata : m_d_hold);
    end
  end

  task automatic set_in(input logic ir, input logic [5:0] ia, input logic dr, input logic dwe,
                        input logic [5:0] da, input logic [31:0] dwd, input logic [3:0] dbe);
    if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  logic [9:0] if_pat, d_pat;
  int rv_cnt;

  initial begin
    repeat (2) @(posedge clk);
    #1; preload = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    tick; rst = 1'b0;

    // Fetch only
    set_in(1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); chk("f0_gnt", 32'(if_gnt), 32'd1); chk("f0_dgnt", 32'(d_gnt), 32'd0);
    tick; set_in(1'b1, 6'd1, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); chk("f1_gnt", 32'(if_gnt), 32'd1); chk("f0_data", if_rdata, 32'h00002303);
    tick; set_in(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); chk("f1_rvalid", 32'(if_rvalid), 32'd1); chk("f1_data", if_rdata, 32'h00402383);
    tick;

    // Contention after a fetch of word0
    set_in(1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    tick; set_in(1'b1, 6'd0, 1'b1, 1'b0, 6'd2, 32'd0, 4'd0);
    @(negedge clk); chk("ct_dgnt", 32'(d_gnt), 32'd1); chk("ct_ignt", 32'(if_gnt), 32'd0);
    tick; set_in(1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk);
    chk("ct_drvalid", 32'(d_rvalid), 32'd1); chk("ct_ddata", d_rdata, 32'hCAFE0002);
    chk("ct_ihold", if_rdata, 32'h00002303); chk("ct_starve", 32'(dut.r_starve_cnt), 32'd1);
    tick; set_in(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    tick;

    // Starvation guard under continuous contention
    rv_cnt = 0;
    set_in(1'b1, 6'd3, 1'b1, 1'b0, 6'd4, 32'd0, 4'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); if_pat[i] = if_gnt; d_pat[i] = d_gnt; rv_cnt += int'(if_rvalid);
      tick;
    end
    set_in(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); rv_cnt += int'(if_rvalid);
    tick;
    chk("sv_ipat", 32'(if_pat), 32'h210);
    chk("sv_dpat", 32'(d_pat), 32'h1EF);
    chk("sv_rvcnt", 32'(rv_cnt), 32'd2);

    // Byte-enable stores, then load; zero-enable store is a granted no-op
    set_in(1'b0, 6'd0, 1'b1, 1'b1, 6'd10, 32'hDEADBEEF, 4'b1111);
    @(negedge clk); chk("st0_gnt", 32'(d_gnt), 32'd1);
    tick; set_in(1'b0, 6'd0, 1'b1, 1'b1, 6'd10, 32'h12345678, 4'b0011);
    @(negedge clk); chk("st0_ack", 32'(d_rvalid), 32'd1);
    tick; set_in(1'b0, 6'd0, 1'b1, 1'b0, 6'd10, 32'd0, 4'd0);
    @(negedge clk); chk("st1_ack", 32'(d_rvalid), 32'd1);
    tick; set_in(1'b0, 6'd0, 1'b1, 1'b1, 6'd10, 32'hFFFFFFFF, 4'b0000);
    @(negedge clk); chk("ld_data", d_rdata, 32'hDEAD5678); chk("be0_gnt", 32'(d_gnt), 32'd1);
    tick; set_in(1'b0, 6'd0, 1'b1, 1'b0, 6'd10, 32'd0, 4'd0);
    @(negedge clk); chk("be0_ack", 32'(d_rvalid), 32'd1); chk("be0_hold", d_rdata, 32'hDEAD5678);
    tick; set_in(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); chk("be0_ld", d_rdata, 32'hDEAD5678);
    tick;

    // Reset asserted while a fetch is granted
    set_in(1'b1, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rm_ignt", 32'(if_gnt), 32'd0); chk("rm_rvalid", 32'(if_rvalid), 32'd0);
    chk("rm_irdata", if_rdata, 32'd0); chk("rm_drdata", d_rdata, 32'd0);
    tick; set_in(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0); rst = 1'b0;
    @(negedge clk); chk("rm_norv", 32'(if_rvalid), 32'd0);
    tick; set_in(1'b1, 6'd1, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); chk("rm_fgnt", 32'(if_gnt), 32'd1);
    tick; set_in(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 32'd0, 4'd0);
    @(negedge clk); chk("rm_frv", 32'(if_rvalid), 32'd1); chk("rm_fdata", if_rdata, 32'h00402383);
    tick;

    // Idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_en", 32'(mem_en), 32'd0); chk("idle_we", 32'(mem_we), 32'd0);
      chk("idle_rv", 32'(if_rvalid | d_rvalid), 32'd0);
      chk("idle_irdata", if_rdata, 32'h00402383); chk("idle_drdata", d_rdata, 32'd0);
      tick;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
